// File: rtl/bp_cce_hybrid_mem_cmd_arbiter_if.sv
// BedRock stream channel carrying one message header (stable across the message)
// plus per-beat data, valid, last and a ready-and handshake.
interface bp_cce_hybrid_mem_cmd_arbiter_if
   #(parameter int header_width_p = 48
   , parameter int data_width_p   = 64
   );
   logic [header_width_p-1:0] header;
   logic [data_width_p-1:0]   data;
   logic                      v;
   logic                      last;
   logic                      ready_and;

   modport master (output header, data, v, last, input ready_and);
   modport slave  (input header, data, v, last, output ready_and);
endinterface

// File: rtl/bp_cce_hybrid_mem_cmd_arbiter.sv
// Round-robin merge of two BedRock stream sources onto the CCE memory command channel;
// the grant is held for a whole message and each message is first counted pending.
module bp_cce_hybrid_mem_cmd_arbiter
   #(parameter int paddr_width_p = 32
   , parameter bit pending_en_p  = 1'b1
   )
   (input  logic                                   clk
   , input  logic                                  reset
   , bp_cce_hybrid_mem_cmd_arbiter_if.slave        src0
   , bp_cce_hybrid_mem_cmd_arbiter_if.slave        src1
   , bp_cce_hybrid_mem_cmd_arbiter_if.master       mem_cmd
   , output logic                                  pending_w_v
   , input  logic                                  pending_w_yumi
   , output logic [paddr_width_p-1:0]              pending_w_addr
   , output logic                                  pending_w_addr_bypass_hash
   , output logic                                  pending_up
   , output logic                                  pending_down
   , output logic                                  pending_clear
   );

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_pend = 2'd1,
      e_send = 2'd2
   } state_e;

   state_e                   state_r, state_n;
   logic                     grant_r, grant_n;
   logic                     rr_ptr_r, rr_ptr_n;
   logic [paddr_width_p-1:0] addr_r, addr_n;
   logic                     winner;
   logic                     in_send;
   logic                     sel_v;
   logic                     sel_last;

   // Output muxing and next-state selection; outputs are forced quiet while reset is high.
   always_comb begin
      state_n  = state_r;
      grant_n  = grant_r;
      rr_ptr_n = rr_ptr_r;
      addr_n   = addr_r;
      winner   = 1'b0;
      in_send  = (state_r == e_send) && !reset;
      sel_v    = grant_r ? src1.v    : src0.v;
      sel_last = grant_r ? src1.last : src0.last;

      pending_w_v    = (state_r == e_pend) && !reset;
      mem_cmd.header = grant_r ? src1.header : src0.header;
      mem_cmd.data   = grant_r ? src1.data   : src0.data;
      mem_cmd.last   = sel_last;
      mem_cmd.v      = in_send && sel_v;
      src0.ready_and = in_send && !grant_r && mem_cmd.ready_and;
      src1.ready_and = in_send &&  grant_r && mem_cmd.ready_and;

      case (state_r)
         e_idle: begin
            // A lone requester wins outright; a tie goes to the priority pointer.
            if (src0.v && src1.v) begin
               winner = rr_ptr_r;
            end else begin
               winner = src1.v;
            end
            if (src0.v || src1.v) begin
               grant_n = winner;
               addr_n  = winner ? src1.header[paddr_width_p-1:0]
                                : src0.header[paddr_width_p-1:0];
               state_n = pending_en_p ? e_pend : e_send;
            end else begin
               state_n = e_idle;
            end
         end
         e_pend: begin
            if (pending_w_yumi) begin
               state_n = e_send;
            end else begin
               state_n = e_pend;
            end
         end
         e_send: begin
            if (sel_v && mem_cmd.ready_and && sel_last) begin
               state_n  = e_idle;
               rr_ptr_n = ~grant_r;
            end else begin
               state_n = e_send;
            end
         end
         default: begin
            state_n = e_idle;
         end
      endcase
   end

   // State, grant, priority pointer and latched message address.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= e_idle;
         grant_r  <= 1'b0;
         rr_ptr_r <= 1'b0;
         addr_r   <= '0;
      end else begin
         state_r  <= state_n;
         grant_r  <= grant_n;
         rr_ptr_r <= rr_ptr_n;
         addr_r   <= addr_n;
      end
   end

   assign pending_w_addr             = addr_r;
   assign pending_w_addr_bypass_hash = 1'b0;
   assign pending_up                 = 1'b1;
   assign pending_down               = 1'b0;
   assign pending_clear              = 1'b0;

endmodule

// File: tb/tb_bp_cce_hybrid_mem_cmd_arbiter.sv
// Directed and randomized bench for the hybrid CCE memory command arbiter; a message-level
// reference model predicts grants, pending writes and every forwarded beat.
module tb_bp_cce_hybrid_mem_cmd_arbiter;
   localparam int paddr_width_lp  = 32;
   localparam int header_width_lp = 48;
   localparam int data_width_lp   = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic yumi = 1'b0;
   logic mem_ready = 1'b0;

   logic                      pending_w_v, bypass, up, down, clear;
   logic [paddr_width_lp-1:0] pending_w_addr;
   logic                      pending_w_v_b, bypass_b, up_b, down_b, clear_b;
   logic [paddr_width_lp-1:0] pending_w_addr_b;

   bp_cce_hybrid_mem_cmd_arbiter_if #(.header_width_p(header_width_lp), .data_width_p(data_width_lp))
      s0 (), s1 (), mc (), s0b (), s1b (), mcb ();

   always #5 clk = ~clk;

   bp_cce_hybrid_mem_cmd_arbiter #(.paddr_width_p(paddr_width_lp), .pending_en_p(1'b1)) dut
      (.clk(clk), .reset(reset), .src0(s0), .src1(s1), .mem_cmd(mc)
      , .pending_w_v(pending_w_v), .pending_w_yumi(yumi), .pending_w_addr(pending_w_addr)
      , .pending_w_addr_bypass_hash(bypass), .pending_up(up), .pending_down(down)
      , .pending_clear(clear));

   bp_cce_hybrid_mem_cmd_arbiter #(.paddr_width_p(paddr_width_lp), .pending_en_p(1'b0)) dut_nopend
      (.clk(clk), .reset(reset), .src0(s0b), .src1(s1b), .mem_cmd(mcb)
      , .pending_w_v(pending_w_v_b), .pending_w_yumi(1'b0), .pending_w_addr(pending_w_addr_b)
      , .pending_w_addr_bypass_hash(bypass_b), .pending_up(up_b), .pending_down(down_b)
      , .pending_clear(clear_b));

   assign s0b.header = s0.header;
   assign s0b.data   = s0.data;
   assign s0b.v      = s0.v;
   assign s0b.last   = s0.last;
   assign s1b.header = s1.header;
   assign s1b.data   = s1.data;
   assign s1b.v      = s1.v;
   assign s1b.last   = s1.last;
   assign mcb.ready_and = 1'b1;
   assign mc.ready_and  = mem_ready;

   int n_checks = 0;
   int n_errors = 0;

   // source stimulus state
   bit          has [2];
   bit          v [2];
   bit          consumed [2];
   logic [31:0] addr [2];
   logic [15:0] meta [2];
   logic [63:0] base [2];
   int          nb [2];
   int          bi [2];
   bit          auto_gen = 1'b0;
   bit          bubbles = 1'b0;
   bit          yumi_rand = 1'b0;
   int          rdy_mode = 0;
   int          yumi_hold = 0;

   // reference model: arbiter busy with source cur, pending write done, fairness pointer
   bit busy = 1'b0;
   bit cur = 1'b0;
   bit pend_done = 1'b0;
   bit rr = 1'b0;

   // observations
   int          n_pv, n_pv_hs, n_mv, n_hs, n_last_hs, n_rdy1;
   logic [31:0] paddr_q [$];
   bit          pvb_seen = 1'b0;
   logic        b_v, b_last, b_rdy0, b_rdy1;
   logic [63:0] b_data;
   logic [47:0] b_header;
   logic [31:0] b_paddr;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic apply_src();
      s0.v      = v[0];
      s0.header = {meta[0], addr[0]};
      s0.data   = base[0] + 64'(bi[0]);
      s0.last   = (bi[0] == nb[0] - 1);
      s1.v      = v[1];
      s1.header = {meta[1], addr[1]};
      s1.data   = base[1] + 64'(bi[1]);
      s1.last   = (bi[1] == nb[1] - 1);
   endtask

   task automatic new_msg(input int k, input logic [31:0] a, input int beats, input bit v0);
      has[k]  = 1'b1;
      addr[k] = a;
      meta[k] = 16'($urandom);
      base[k] = {$urandom, $urandom};
      nb[k]   = beats;
      bi[k]   = 0;
      v[k]    = v0;
      apply_src();
   endtask

   task automatic clear_stats();
      n_pv = 0; n_pv_hs = 0; n_mv = 0; n_hs = 0; n_last_hs = 0; n_rdy1 = 0;
      paddr_q.delete();
   endtask

   task automatic observe();
      if (pending_w_v) n_pv++;
      if (pending_w_v && yumi) begin
         n_pv_hs++;
         paddr_q.push_back(pending_w_addr);
      end
      if (mc.v) n_mv++;
      if (mc.v && mem_ready) begin
         n_hs++;
         if (mc.last) n_last_hs++;
      end
      if (s1.ready_and) n_rdy1++;
      if (pending_w_v_b) pvb_seen = 1'b1;
      b_v = mcb.v; b_last = mcb.last; b_data = mcb.data; b_header = mcb.header;
      b_paddr = pending_w_addr_b; b_rdy0 = s0b.ready_and; b_rdy1 = s1b.ready_and;
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < 2; k++) begin
         if (consumed[k]) begin
            consumed[k] = 1'b0;
            bi[k]++;
            if (bi[k] == nb[k]) begin
               has[k] = 1'b0;
               v[k]   = 1'b0;
            end else begin
               v[k] = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
         end else if (has[k] && !v[k]) begin
            v[k] = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         if (!has[k] && auto_gen && $urandom_range(0, 3) == 0)
            new_msg(k, $urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end
      case (rdy_mode)
         0: mem_ready = 1'b1;
         1: mem_ready = ~mem_ready;
         default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      if (yumi_hold > 0) begin
         yumi = 1'b0;
         yumi_hold--;
      end else begin
         yumi = yumi_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      apply_src();
   endtask

   task automatic step();
      bit send_exp;
      @(negedge clk);
      observe();
      if (reset) begin
         check_eq("rst_cmd_v", 64'(mc.v), 64'd0);
         check_eq("rst_pend_v", 64'(pending_w_v), 64'd0);
         check_eq("rst_src0_ready", 64'(s0.ready_and), 64'd0);
         check_eq("rst_src1_ready", 64'(s1.ready_and), 64'd0);
         busy = 1'b0; rr = 1'b0; pend_done = 1'b0; bi[0] = 0; bi[1] = 0;
      end else begin
         send_exp = busy && pend_done && v[cur];
         check_eq("pend_v", 64'(pending_w_v), 64'(busy && !pend_done));
         if (busy && !pend_done)
            check_eq("pend_addr", 64'(pending_w_addr), 64'(addr[cur]));
         check_eq("cmd_v", 64'(mc.v), 64'(send_exp));
         if (send_exp) begin
            check_eq("cmd_header", 64'(mc.header), 64'({meta[cur], addr[cur]}));
            check_eq("cmd_data", mc.data, base[cur] + 64'(bi[cur]));
            check_eq("cmd_last", 64'(mc.last), 64'(bi[cur] == nb[cur] - 1));
         end
         check_eq("src0_ready", 64'(s0.ready_and), 64'(busy && pend_done && !cur && mem_ready));
         check_eq("src1_ready", 64'(s1.ready_and), 64'(busy && pend_done && cur && mem_ready));
         // advance the model to what happens at the coming edge
         if (!busy) begin
            if (v[0] || v[1]) begin
               cur       = (v[0] && v[1]) ? rr : v[1];
               busy      = 1'b1;
               pend_done = 1'b0;
            end
         end else if (!pend_done) begin
            if (yumi) pend_done = 1'b1;
         end else if (v[cur] && mem_ready) begin
            consumed[cur] = 1'b1;
            if (bi[cur] == nb[cur] - 1) begin
               busy = 1'b0;
               rr   = !cur;
            end
         end
      end
      @(posedge clk);
      #1;
      drive_inputs();
   endtask

   task automatic run_until_idle(input string tag, input int max_cycles);
      int c = 0;
      while ((has[0] || has[1] || busy) && c < max_cycles) begin
         step();
         c++;
      end
      check_eq({tag, "_drained"}, 64'(has[0] || has[1] || busy), 64'd0);
      step();
   endtask

   initial begin
      apply_src();
      step();
      step();

      // single 2-beat message from source 0, immediate yumi; also the no-pending instance
      reset = 1'b0;
      clear_stats();
      new_msg(0, 32'h8000_0040, 2, 1'b1);
      step();
      check_eq("nopend_idle_v", 64'(b_v), 64'd0);
      step();
      check_eq("nopend_first_v", 64'(b_v), 64'd1);
      check_eq("nopend_addr", 64'(b_paddr), 64'h8000_0040);
      check_eq("nopend_header", 64'(b_header), 64'({meta[0], addr[0]}));
      check_eq("nopend_data", b_data, base[0]);
      check_eq("nopend_last", 64'(b_last), 64'd0);
      check_eq("nopend_rdy0", 64'(b_rdy0), 64'd1);
      check_eq("nopend_rdy1", 64'(b_rdy1), 64'd0);
      for (int i = 0; i < 5; i++) step();
      check_eq("t1_pend_cycles", 64'(n_pv), 64'd1);
      check_eq("t1_pend_addr", 64'(paddr_q[0]), 64'h8000_0040);
      check_eq("t1_cmd_cycles", 64'(n_mv), 64'd2);
      check_eq("t1_last_count", 64'(n_last_hs), 64'd1);

      // both sources valid when reset releases: source 0 first, priority back to 0 after
      reset = 1'b1;
      clear_stats();
      new_msg(0, 32'h0000_1000, 3, 1'b1);
      new_msg(1, 32'h0000_2000, 2, 1'b1);
      step();
      reset = 1'b0;
      run_until_idle("t2a", 40);
      new_msg(0, 32'h0000_3000, 1, 1'b1);
      new_msg(1, 32'h0000_4000, 1, 1'b1);
      run_until_idle("t2b", 40);
      check_eq("t2_pend_count", 64'(paddr_q.size()), 64'd4);
      check_eq("t2_pend_first", 64'(paddr_q[0]), 64'h0000_1000);
      check_eq("t2_pend_second", 64'(paddr_q[1]), 64'h0000_2000);
      check_eq("t2_pend_third", 64'(paddr_q[2]), 64'h0000_3000);

      // yumi withheld five cycles while source 1 arrives during the pending phase
      clear_stats();
      yumi = 1'b0;
      yumi_hold = 5;
      new_msg(0, 32'h0000_5000, 2, 1'b1);
      step();
      step();
      new_msg(1, 32'h0000_6000, 2, 1'b1);
      for (int i = 0; i < 4; i++) step();
      check_eq("t3_pend_held", 64'(n_pv), 64'd5);
      check_eq("t3_no_cmd", 64'(n_mv), 64'd0);
      check_eq("t3_src1_blocked", 64'(n_rdy1), 64'd0);
      run_until_idle("t3", 40);
      check_eq("t3_order0", 64'(paddr_q[0]), 64'h0000_5000);
      check_eq("t3_order1", 64'(paddr_q[1]), 64'h0000_6000);

      // downstream ready toggling every cycle across a 4-beat message
      clear_stats();
      rdy_mode = 1;
      new_msg(0, 32'h0000_7000, 4, 1'b1);
      run_until_idle("t4", 40);
      check_eq("t4_beats", 64'(n_hs), 64'd4);
      check_eq("t4_last", 64'(n_last_hs), 64'd1);
      rdy_mode = 0;

      // reset after the first of four beats; the message is resent with a fresh pending write
      clear_stats();
      new_msg(0, 32'h0000_8000, 4, 1'b1);
      for (int c = 0; c < 20 && bi[0] != 1; c++) step();
      check_eq("t5_first_beat", 64'(bi[0]), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      run_until_idle("t5", 40);
      check_eq("t5_pend_writes", 64'(n_pv_hs), 64'd2);
      check_eq("t5_beats", 64'(n_hs), 64'd5);
      check_eq("t5_last", 64'(n_last_hs), 64'd1);

      // randomized traffic with bubbles, random yumi and random downstream ready
      auto_gen = 1'b1;
      bubbles = 1'b1;
      yumi_rand = 1'b1;
      rdy_mode = 2;
      for (int i = 0; i < 3000; i++) step();
      auto_gen = 1'b0;
      run_until_idle("random", 400);

      check_eq("nopend_never_pending", 64'(pvb_seen), 64'd0);
      check_eq("const_bypass", 64'(bypass), 64'd0);
      check_eq("const_up", 64'(up), 64'd1);
      check_eq("const_down", 64'(down), 64'd0);
      check_eq("const_clear", 64'(clear), 64'd0);
      check_eq("nopend_consts", 64'({bypass_b, up_b, down_b, clear_b}), 64'b0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
      $finish;
   end
endmodule
